alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares the board's single small signed ALU (add/sub/and/or, 3-bit operands, 7-bit result, overflow flag) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the operands and select onto the ALU. It captures the ALU result and overflow, then returns them with the requester ID over a response valid/ready handshake. It sits between the switch/requester logic in top and the ALU, and feeds LED/SEG display logic.

Parameters:
NBITS_OPERAND, 3, signed operand width (A, B)
NBITS_OPERATION_SELECT, 2, ALU function select width (00 add, 01 sub, 10 and, 11 or)
NBITS_OPERATION_RESULT, 7, signed ALU result width
NBITS_COUNT, 8, width of completed-operation counter

Ports:
clk_2  input  1  system clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
req_valid  input  2  request valid, bit i = requester i
req_ready  output  2  request accepted (bit i), combinational, at most one bit high
req0_A, req0_B  input  NBITS_OPERAND  requester 0 signed operands
req0_F  input  NBITS_OPERATION_SELECT  requester 0 function
req1_A, req1_B  input  NBITS_OPERAND  requester 1 signed operands
req1_F  input  NBITS_OPERATION_SELECT  requester 1 function
alu_A, alu_B  output  NBITS_OPERAND  operands to ALU (registered)
alu_F  output  NBITS_OPERATION_SELECT  function to ALU (registered)
alu_result  input  NBITS_OPERATION_RESULT  combinational ALU result
alu_overflow  input  1  ALU overflow/underflow flag
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester that issued the response
rsp_result  output  NBITS_OPERATION_RESULT  captured result
rsp_overflow  output  1  captured overflow flag
busy  output  1  high when state != IDLE
op_count  output  NBITS_COUNT  completed responses, wraps

Behaviour:
- Clock/reset: one clock, clk_2. reset_n is asynchronous and active-low. While reset_n=0: state=IDLE, alu_A/alu_B/alu_F=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, op_count=0, last_grant=1, req_ready=0 regardless of req_valid.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - No req_valid bit set: req_ready=0, stay in IDLE.
  - Exactly one bit set: grant that requester.
  - Both bits set: grant ~last_grant. Requester 0 therefore wins the first arbitration after reset.
- IDLE, accept: req_ready[grant]=1 combinationally in the same cycle. The handshake completes at that edge:
  - latch reqG_A/B/F into alu_A/B/F
  - latch grant into rsp_id and last_grant
  - go to EXEC
- EXEC (exactly 1 cycle): ALU inputs are stable. At the end of the cycle, capture alu_result into rsp_result and alu_overflow into rsp_overflow, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_overflow hold stable until the handshake.
  - On rsp_valid & rsp_ready: clear rsp_valid, increment op_count (modulo 2^NBITS_COUNT, 255 -> 0), go to IDLE.
  - rsp_ready low: stay, no new accepts.
- Latency: accept at edge k, rsp_valid high after edge k+1. Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP).
- req_ready is 0 in EXEC and RESP. Requests held valid wait; no request is ever dropped or duplicated.
- alu_A/B/F hold their last issued values outside EXEC; no return to 0 after the operation.
- No arithmetic in this block; width and sign handling belong to the ALU. rsp_result is a pass-through capture.
- busy = (state != IDLE).
- Reset mid-operation (EXEC or RESP): the transaction is discarded with no response. All registers go to reset values and op_count is not incremented.
- A requester deasserting req_valid before acceptance is legal; nothing is latched.

Test Plan:
- Reset: hold reset_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, op_count=0, alu_A/B/F=0. Release -> requester 0 granted first.
- Single request: req0 A=3, B=2, F=00, bench ALU model -> req_ready=2'b01 for one cycle. rsp_valid one edge after accept, rsp_id=0, rsp_result=5, rsp_overflow=1.
- Subtraction underflow: req1 A=-4, B=3, F=01 -> rsp_id=1, rsp_result=-7 (7'b1111001), rsp_overflow=1. Then A=1, B=3, F=10 -> rsp_result=1, rsp_overflow=0.
- Fairness: both req_valid held high, rsp_ready=1 -> grant sequence 0,1,0,1. Accepts exactly 3 cycles apart; busy low only in the IDLE cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, op_count unchanged. On rsp_ready=1, op_count +1.
- Wrap and mid-op reset: 256 completed transactions -> op_count=0. Then assert reset_n=0 during EXEC -> no response, op_count=0, state IDLE.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one small signed ALU between two requesters using round-robin
//   arbitration. One operation is in flight at a time: IDLE accepts a
//   request, EXEC lets the ALU settle for one cycle, and RESP holds the
//   captured result until the consumer takes it.
//
// Ports
//   clk_2, reset_n          clock (rising edge), async active-low reset
//   req_valid / req_ready   per-requester request handshake (bit i = req i)
//   req0_A/B/F, req1_A/B/F  operands and function select of each requester
//   alu_A/B/F               registered operands/select driven to the ALU
//   alu_result/overflow     combinational ALU outputs, captured in EXEC
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester that issued the response
//   rsp_result/overflow     captured ALU result and flag
//   busy                    high whenever the FSM is not in IDLE
//   op_count                completed responses, wraps at 2^NBITS_COUNT
module alu_rr_scheduler #(
  parameter int NBITS_OPERAND          = 3,
  parameter int NBITS_OPERATION_SELECT = 2,
  parameter int NBITS_OPERATION_RESULT = 7,
  parameter int NBITS_COUNT            = 8
) (
  input  logic                              clk_2,
  input  logic                              reset_n,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [NBITS_OPERAND-1:0]          req0_A,
  input  logic [NBITS_OPERAND-1:0]          req0_B,
  input  logic [NBITS_OPERATION_SELECT-1:0] req0_F,
  input  logic [NBITS_OPERAND-1:0]          req1_A,
  input  logic [NBITS_OPERAND-1:0]          req1_B,
  input  logic [NBITS_OPERATION_SELECT-1:0] req1_F,
  output logic [NBITS_OPERAND-1:0]          alu_A,
  output logic [NBITS_OPERAND-1:0]          alu_B,
  output logic [NBITS_OPERATION_SELECT-1:0] alu_F,
  input  logic [NBITS_OPERATION_RESULT-1:0] alu_result,
  input  logic                              alu_overflow,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_id,
  output logic [NBITS_OPERATION_RESULT-1:0] rsp_result,
  output logic                              rsp_overflow,
  output logic                              busy,
  output logic [NBITS_COUNT-1:0]            op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic                                last_grant_q, last_grant_d;
  logic [NBITS_OPERAND-1:0]            alu_a_q, alu_a_d;
  logic [NBITS_OPERAND-1:0]            alu_b_q, alu_b_d;
  logic [NBITS_OPERATION_SELECT-1:0]   alu_f_q, alu_f_d;
  logic                                rsp_valid_q, rsp_valid_d;
  logic                                rsp_id_q, rsp_id_d;
  logic [NBITS_OPERATION_RESULT-1:0]   rsp_result_q, rsp_result_d;
  logic                                rsp_overflow_q, rsp_overflow_d;
  logic [NBITS_COUNT-1:0]              op_count_q, op_count_d;
  logic                                grant;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_f_d        = alu_f_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    op_count_d     = op_count_q;
    grant          = 1'b0;
    req_ready      = 2'b00;

    unique case (state_q)
      IDLE: begin
        // reset_n gates the handshake so req_ready stays low while reset
        // is held, even though the state register already reads IDLE.
        if (reset_n && (req_valid != 2'b00)) begin
          // On contention the requester that did not win last time goes.
          if (req_valid == 2'b11) grant = ~last_grant_q;
          else                    grant = req_valid[1];
          req_ready    = grant ? 2'b10 : 2'b01;
          alu_a_d      = grant ? req1_A : req0_A;
          alu_b_d      = grant ? req1_B : req0_B;
          alu_f_d      = grant ? req1_F : req0_F;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d   = alu_result;
        rsp_overflow_d = alu_overflow;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + {{(NBITS_COUNT-1){1'b0}}, 1'b1};
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_f_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_f_q        <= alu_f_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      op_count_q     <= op_count_d;
    end
  end

  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_F        = alu_f_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign op_count     = op_count_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

  logic              clk_2;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic signed [2:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0]        req0_F, req1_F;
  logic signed [2:0] alu_A, alu_B;
  logic [1:0]        alu_F;
  logic [6:0]        alu_result;
  logic              alu_overflow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [6:0]        rsp_result;
  logic              rsp_overflow;
  logic              busy;
  logic [7:0]        op_count;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  alu_rr_scheduler dut (
    .clk_2(clk_2), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_F(req0_F),
    .req1_A(req1_A), .req1_B(req1_B), .req1_F(req1_F),
    .alu_A(alu_A), .alu_B(alu_B), .alu_F(alu_F),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .busy(busy), .op_count(op_count)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Behavioural model of the board ALU: 3-bit signed operands, 7-bit result,
  // overflow when an add/sub result leaves the 3-bit signed range.
  int m_a, m_b, m_r;
  always_comb begin
    m_a = alu_A;
    m_b = alu_B;
    m_r = 0;
    case (alu_F)
      2'b00: m_r = m_a + m_b;
      2'b01: m_r = m_a - m_b;
      2'b10: m_r = alu_A & alu_B;
      default: m_r = alu_A | alu_B;
    endcase
    alu_result   = m_r[6:0];
    alu_overflow = (alu_F[1] == 1'b0) && ((m_r > 3) || (m_r < -4));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_A = 3'sd1; req0_B = 3'sd1; req0_F = 2'b00;
    req1_A = 3'sd2; req1_B = 3'sd1; req1_F = 2'b01;
    repeat (3) @(negedge clk_2);
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    total++; if ({alu_A, alu_B, alu_F} !== 8'd0) begin bad++; $display("FAIL reset_alu_regs: got %h want 00", {alu_A, alu_B, alu_F}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk_2);
    reset_n = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_single;
    @(negedge clk_2);
    req0_A = 3'sd3; req0_B = 3'sd2; req0_F = 2'b00; req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
    @(negedge clk_2);
    req_valid = 2'b00;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL single_exec_ready: got %b want 00", req_ready); end
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_state: got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid); end
    total++; if ({alu_A, alu_B, alu_F} !== {3'd3, 3'd2, 2'b00}) begin bad++; $display("FAIL single_alu_regs: got %h want %h", {alu_A, alu_B, alu_F}, {3'd3, 3'd2, 2'b00}); end
    @(negedge clk_2);
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_rsp_id: got %b want 0", rsp_id); end
    total++; if (rsp_result !== 7'd5) begin bad++; $display("FAIL single_rsp_result: got %b want 0000101", rsp_result); end
    total++; if (rsp_overflow !== 1'b1) begin bad++; $display("FAIL single_rsp_overflow: got %b want 1", rsp_overflow); end
    @(negedge clk_2);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done_state: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL single_op_count: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_sub_and;
    // -4 - 3 = -7, outside 3-bit range
    @(negedge clk_2);
    req1_A = -3'sd4; req1_B = 3'sd3; req1_F = 2'b01; req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL sub_req_ready: got %b want 10", req_ready); end
    @(negedge clk_2);
    req_valid = 2'b00;
    @(negedge clk_2);
    #1;
    total++; if (rsp_id !== 1'b1) begin bad++; $display("FAIL sub_rsp_id: got %b want 1", rsp_id); end
    total++; if (rsp_result !== 7'b1111001) begin bad++; $display("FAIL sub_rsp_result: got %b want 1111001", rsp_result); end
    total++; if (rsp_overflow !== 1'b1) begin bad++; $display("FAIL sub_rsp_overflow: got %b want 1", rsp_overflow); end
    @(negedge clk_2);
    exp_cnt = exp_cnt + 8'd1;
    // 1 & 3 = 1, no overflow
    req1_A = 3'sd1; req1_B = 3'sd3; req1_F = 2'b10; req_valid = 2'b10;
    @(negedge clk_2);
    req_valid = 2'b00;
    @(negedge clk_2);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin bad++; $display("FAIL and_rsp_hdr: got valid=%b id=%b want 1 1", rsp_valid, rsp_id); end
    total++; if (rsp_result !== 7'b0000001) begin bad++; $display("FAIL and_rsp_result: got %b want 0000001", rsp_result); end
    total++; if (rsp_overflow !== 1'b0) begin bad++; $display("FAIL and_rsp_overflow: got %b want 0", rsp_overflow); end
    @(negedge clk_2);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL sub_op_count: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_fairness;
    // req0: 1+1 = 2; req1: -1 | -2 = -1 (7'h7F). Grant sequence 0,1,0,1.
    logic [3:0] seq = 4'b1010;
    logic [6:0] res0 = 7'd2;
    logic [6:0] res1 = 7'h7F;
    @(negedge clk_2);
    req0_A = 3'sd1; req0_B = 3'sd1; req0_F = 2'b00;
    req1_A = -3'sd1; req1_B = -3'sd2; req1_F = 2'b11;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) begin
        total++; if (req_ready !== (seq[c/3] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fair_grant_%0d: got %b want %b", c/3, req_ready, (seq[c/3] ? 2'b10 : 2'b01)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_busy_idle_%0d: got %b want 0", c, busy); end
      end else begin
        total++; if (req_ready !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL fair_busy_%0d: got ready=%b busy=%b want 00 1", c, req_ready, busy); end
      end
      if (c % 3 == 2) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== seq[c/3]) begin bad++; $display("FAIL fair_rsp_id_%0d: got valid=%b id=%b want 1 %b", c/3, rsp_valid, rsp_id, seq[c/3]); end
        total++; if (rsp_result !== (seq[c/3] ? res1 : res0)) begin bad++; $display("FAIL fair_rsp_result_%0d: got %h want %h", c/3, rsp_result, (seq[c/3] ? res1 : res0)); end
      end
      @(negedge clk_2);
    end
    req_valid = 2'b00;
    exp_cnt = exp_cnt + 8'd4;
    #1;
    total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL fair_op_count: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_backpressure;
    // -4 + -4 = -8 (7'b1111000), overflow
    @(negedge clk_2);
    req0_A = -3'sd4; req0_B = -3'sd4; req0_F = 2'b00; req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clk_2);
    req_valid = 2'b00;
    @(negedge clk_2);
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_req_ready_%0d: got %b want 00", c, req_ready); end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 7'b1111000 || rsp_overflow !== 1'b1) begin
        bad++; $display("FAIL bp_rsp_hold_%0d: got v=%b id=%b r=%b o=%b want 1 0 1111000 1", c, rsp_valid, rsp_id, rsp_result, rsp_overflow);
      end
      total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL bp_op_count_%0d: got %0d want %0d", c, op_count, exp_cnt); end
      @(negedge clk_2);
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(negedge clk_2);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    total++; if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got cnt=%0d v=%b want %0d 0", op_count, rsp_valid, exp_cnt); end
  endtask

  task automatic test_wrap_and_midreset;
    @(negedge clk_2);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    exp_cnt = 8'd0;
    req0_A = 3'sd1; req0_B = 3'sd2; req0_F = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_2);
      if (i == 255) begin
        total++; if (op_count !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", op_count); end
      end
      req_valid = 2'b01;
      @(negedge clk_2);
      req_valid = 2'b00;
      @(negedge clk_2);
    end
    @(negedge clk_2);
    #1;
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
    // one more transaction so the reset has something to clear
    req_valid = 2'b01;
    @(negedge clk_2);
    req_valid = 2'b00;
    repeat (2) @(negedge clk_2);
    #1;
    total++; if (op_count !== 8'd1) begin bad++; $display("FAIL midrst_pre_count: got %0d want 1", op_count); end
    req0_A = 3'sd2; req_valid = 2'b01;
    @(negedge clk_2);
    req_valid = 2'b00;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_in_exec: got busy=%b want 1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 8'd0) begin bad++; $display("FAIL midrst_clear: got busy=%b v=%b cnt=%0d want 0 0 0", busy, rsp_valid, op_count); end
    total++; if ({alu_A, alu_B, alu_F} !== 8'd0 || rsp_result !== 7'd0) begin bad++; $display("FAIL midrst_regs: got alu=%h res=%h want 00 00", {alu_A, alu_B, alu_F}, rsp_result); end
    @(negedge clk_2);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_2);
      #1;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin bad++; $display("FAIL midrst_after_%0d: got v=%b busy=%b cnt=%0d want 0 0 0", c, rsp_valid, busy, op_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sub_and();
    test_fairness();
    test_backpressure();
    test_wrap_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
